// File: rtl/load_unit.sv
// rtl/load_unit.sv - MEM-stage load path with alignment check, memory handshake and extension
module load_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rd,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              exc_adel,
  output logic              exc_tmo,
  output logic [ADDR_W-1:0] exc_addr
);

  // Byte-offset width inside one memory word.
  localparam int OFFW = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [7:0]        cnt;
  logic              legal;
  logic              accept;
  logic              reject;
  logic              done;
  logic              tmo;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;

  // Opcode legality and natural alignment of the presented request.
  always_comb begin
    legal = 1'b0;
    case (req_op)
      3'b000, 3'b001: legal = 1'b1;
      3'b010, 3'b011: legal = ~req_addr[0];
      3'b100:         legal = (req_addr[OFFW-1:0] == '0);
      default:        legal = 1'b0;
    endcase
  end

  // Next state plus the one-cycle events that drive the datapath.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (legal) begin
            accept   = 1'b1;
            state_nx = WAIT;
          end else begin
            reject = 1'b1;
          end
        end
      end
      WAIT: begin
        // Data arriving on the last allowed cycle still counts as a completion.
        if (mem_ready) begin
          done     = 1'b1;
          state_nx = RESP;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          tmo      = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  assign stall    = (state == WAIT) | accept;
  assign mem_req  = (state == WAIT);
  assign mem_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};

  // Lane select by shifting the addressed byte down to bit 0, then extend.
  always_comb begin
    shifted = mem_rdata >> {addr_q[OFFW-1:0], 3'b000};
    ext     = shifted;
    case (op_q)
      3'b000:  ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b010:  ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b011:  ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  // Request capture, timeout counter, result and exception registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      cnt      <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      exc_adel <= 1'b0;
      exc_tmo  <= 1'b0;
      exc_addr <= '0;
    end else begin
      wb_valid <= done;
      exc_adel <= reject;
      exc_tmo  <= tmo;
      if (accept) begin
        addr_q <= req_addr;
        op_q   <= req_op;
        rd_q   <= req_rd;
        cnt    <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (done) begin
        wb_data <= ext;
        wb_rd   <= rd_q;
      end
      if (reject) begin
        exc_addr <= req_addr;
      end else if (tmo) begin
        exc_addr <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - randomized self-checking bench for load_unit at 32 and 64 bit widths
module tb_load_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rv32, rv64;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic        mem_ready;
  logic [63:0] mem_rdata;

  logic        stall32, mem_req32, wb_valid32, exc_adel32, exc_tmo32;
  logic [31:0] mem_addr32, exc_addr32, wb_data32;
  logic [4:0]  wb_rd32;
  logic        stall64, mem_req64, wb_valid64, exc_adel64, exc_tmo64;
  logic [31:0] mem_addr64, exc_addr64;
  logic [63:0] wb_data64;
  logic [4:0]  wb_rd64;

  load_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) u32 (
    .clk(clk), .reset(reset), .req_valid(rv32), .req_addr(req_addr), .req_op(req_op),
    .req_rd(req_rd), .stall(stall32), .mem_req(mem_req32), .mem_addr(mem_addr32),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata[31:0]), .wb_valid(wb_valid32),
    .wb_data(wb_data32), .wb_rd(wb_rd32), .exc_adel(exc_adel32), .exc_tmo(exc_tmo32),
    .exc_addr(exc_addr32)
  );

  load_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(3)) u64 (
    .clk(clk), .reset(reset), .req_valid(rv64), .req_addr(req_addr), .req_op(req_op),
    .req_rd(req_rd), .stall(stall64), .mem_req(mem_req64), .mem_addr(mem_addr64),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_valid(wb_valid64),
    .wb_data(wb_data64), .wb_rd(wb_rd64), .exc_adel(exc_adel64), .exc_tmo(exc_tmo64),
    .exc_addr(exc_addr64)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic        sel = 1'b0;
  logic [63:0] last_data [2];
  logic [4:0]  last_rd   [2];

  logic        o_stall, o_mem_req, o_wb_valid, o_exc_adel, o_exc_tmo;
  logic [31:0] o_mem_addr, o_exc_addr;
  logic [63:0] o_wb_data;
  logic [4:0]  o_wb_rd;

  // Observe whichever instance the current transaction targets.
  always_comb begin
    if (sel) begin
      o_stall = stall64; o_mem_req = mem_req64; o_wb_valid = wb_valid64;
      o_exc_adel = exc_adel64; o_exc_tmo = exc_tmo64; o_mem_addr = mem_addr64;
      o_exc_addr = exc_addr64; o_wb_data = wb_data64; o_wb_rd = wb_rd64;
    end else begin
      o_stall = stall32; o_mem_req = mem_req32; o_wb_valid = wb_valid32;
      o_exc_adel = exc_adel32; o_exc_tmo = exc_tmo32; o_mem_addr = mem_addr32;
      o_exc_addr = exc_addr32; o_wb_data = {32'h0, wb_data32}; o_wb_rd = wb_rd32;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal_m(input logic [2:0] op, input logic [31:0] addr, input int dw);
    if (op > 3'd4) return 1'b0;
    if (op == 3'd2 || op == 3'd3) return (addr % 2) == 0;
    if (op == 3'd4) return (addr % (dw / 8)) == 0;
    return 1'b1;
  endfunction

  // Pick the addressed bytes arithmetically and extend as a signed integer.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] addr,
                                        input logic [63:0] data, input int dw);
    longint unsigned w, b, h;
    longint r;
    int idx;
    idx = int'(addr % (dw / 8));
    w = (dw == 32) ? (data & 64'hFFFF_FFFF) : data;
    b = (w >> (8 * idx)) & 64'hFF;
    h = (w >> (8 * idx)) & 64'hFFFF;
    case (op)
      3'd0:    r = (b >= 128) ? longint'(b) - 256 : longint'(b);
      3'd1:    r = longint'(b);
      3'd2:    r = (h >= 32768) ? longint'(h) - 65536 : longint'(h);
      3'd3:    r = longint'(h);
      default: r = longint'(w);
    endcase
    if (dw == 32) return 64'(r) & 64'hFFFF_FFFF;
    return 64'(r);
  endfunction

  // One load; ready_at is the WAIT cycle (1-based) on which mem_ready is raised.
  task automatic run_load(input logic s, input logic [2:0] op, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [63:0] data, input int ready_at);
    int dw, tmo, n;
    bit ok, completes;
    logic [63:0] exp;
    dw = s ? 64 : 32;
    tmo = s ? 3 : 15;
    ok = legal_m(op, addr, dw);
    exp = model(op, addr, data, dw);
    sel = s;
    @(posedge clk); #1;
    rv32 = ~s; rv64 = s; req_op = op; req_addr = addr; req_rd = rd;
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = ~data;
    @(negedge clk);
    check_eq("stall_present", o_stall, ok);
    check_eq("mem_req_idle", o_mem_req, 0);
    if (!ok) begin
      @(posedge clk); #1;
      rv32 = 1'b0; rv64 = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      check_eq("exc_adel", o_exc_adel, 1);
      check_eq("exc_addr_adel", o_exc_addr, addr);
      check_eq("stall_adel", o_stall, 0);
      check_eq("mem_req_adel", o_mem_req, 0);
      check_eq("wb_valid_adel", o_wb_valid, 0);
      check_eq("exc_tmo_adel", o_exc_tmo, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("exc_adel_pulse", o_exc_adel, 0);
      check_eq("wb_data_hold_adel", o_wb_data, last_data[s]);
      return;
    end
    completes = (ready_at <= tmo);
    n = completes ? ready_at : tmo;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      mem_ready = (k == ready_at);
      mem_rdata = (k == ready_at) ? data : {$urandom, $urandom};
      @(negedge clk);
      check_eq("mem_req_wait", o_mem_req, 1);
      check_eq("stall_wait", o_stall, 1);
      check_eq("mem_addr", o_mem_addr, addr & ~(32'(dw / 8) - 32'd1));
      check_eq("wb_valid_wait", o_wb_valid, 0);
    end
    // RESP cycle: request still held and mem_ready raised with junk, both ignored.
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = ~data;
    @(negedge clk);
    check_eq("stall_resp", o_stall, 0);
    check_eq("mem_req_resp", o_mem_req, 0);
    if (completes) begin
      check_eq("wb_valid", o_wb_valid, 1);
      check_eq("wb_data", o_wb_data, exp);
      check_eq("wb_rd", o_wb_rd, rd);
      check_eq("exc_tmo_norm", o_exc_tmo, 0);
      last_data[s] = exp;
      last_rd[s] = rd;
    end else begin
      check_eq("exc_tmo", o_exc_tmo, 1);
      check_eq("exc_addr_tmo", o_exc_addr, addr);
      check_eq("wb_valid_tmo", o_wb_valid, 0);
      check_eq("wb_data_hold_tmo", o_wb_data, last_data[s]);
    end
    @(posedge clk); #1;
    rv32 = 1'b0; rv64 = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check_eq("wb_valid_pulse", o_wb_valid, 0);
    check_eq("exc_tmo_pulse", o_exc_tmo, 0);
    check_eq("mem_req_after", o_mem_req, 0);
    check_eq("wb_data_hold", o_wb_data, last_data[s]);
    check_eq("wb_rd_hold", o_wb_rd, last_rd[s]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_stall"}, o_stall, 0);
    check_eq({tag, "_mem_req"}, o_mem_req, 0);
    check_eq({tag, "_mem_addr"}, o_mem_addr, 0);
    check_eq({tag, "_wb_valid"}, o_wb_valid, 0);
    check_eq({tag, "_wb_data"}, o_wb_data, 0);
    check_eq({tag, "_wb_rd"}, o_wb_rd, 0);
    check_eq({tag, "_exc_adel"}, o_exc_adel, 0);
    check_eq({tag, "_exc_tmo"}, o_exc_tmo, 0);
    check_eq({tag, "_exc_addr"}, o_exc_addr, 0);
  endtask

  initial begin
    int dw, tmo;
    logic s;
    logic [2:0] op;
    logic [31:0] addr;
    reset = 1'b1; rv32 = 1'b0; rv64 = 1'b0; req_addr = '0; req_op = '0; req_rd = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      last_data[i] = '0;
      last_rd[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; #0 check_reset_outputs("rst32");
    sel = 1'b1; #0 check_reset_outputs("rst64");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases.
    run_load(1'b0, 3'b000, 32'h0000_1003, 5'd7,  64'h0000_0000_80FF_1234, 2);
    run_load(1'b0, 3'b011, 32'h0000_2002, 5'd9,  64'h0000_0000_9ABC_5678, 1);
    run_load(1'b0, 3'b010, 32'h0000_2002, 5'd10, 64'h0000_0000_9ABC_5678, 1);
    run_load(1'b0, 3'b100, 32'h0000_3001, 5'd11, 64'h0000_0000_1111_2222, 1);
    run_load(1'b0, 3'b111, 32'h0000_3000, 5'd12, 64'h0000_0000_1111_2222, 1);
    run_load(1'b0, 3'b100, 32'h0000_5000, 5'd13, 64'h0000_0000_DEAD_BEEF, 99);
    run_load(1'b0, 3'b100, 32'h0000_5004, 5'd14, 64'h0000_0000_CAFE_F00D, 15);
    run_load(1'b1, 3'b000, 32'h0000_0007, 5'd3,  64'h7F00_0000_0000_0000, 1);
    run_load(1'b1, 3'b100, 32'h0000_0004, 5'd4,  64'h0123_4567_89AB_CDEF, 1);
    run_load(1'b1, 3'b100, 32'h0000_0008, 5'd5,  64'h0123_4567_89AB_CDEF, 3);
    run_load(1'b1, 3'b010, 32'h0000_0006, 5'd6,  64'h8001_0000_0000_0000, 9);

    // Reset in the second WAIT cycle, then a late mem_ready.
    sel = 1'b0;
    @(posedge clk); #1;
    rv32 = 1'b1; req_op = 3'b100; req_addr = 32'h0000_4000; req_rd = 5'd21;
    mem_rdata = 64'h5555_AAAA; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("stall_wait2", o_stall, 1);
    @(posedge clk); #1;
    reset = 1'b0; rv32 = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("rstwait");
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("late_ready_wb_valid", o_wb_valid, 0);
    check_eq("late_ready_mem_req", o_mem_req, 0);
    for (int i = 0; i < 2; i++) begin
      last_data[i] = '0;
      last_rd[i] = '0;
    end

    // Randomized loads across both widths.
    for (int it = 0; it < 150; it++) begin
      s = 1'($urandom_range(0, 1));
      dw = s ? 64 : 32;
      tmo = s ? 3 : 15;
      op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & ~(32'(dw / 8) - 32'd1);
      run_load(s, op, addr, 5'($urandom), {$urandom, $urandom}, $urandom_range(1, tmo + 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_unit.md
# load_unit

Parametrised load-path block between the MEM stage and data memory. It accepts a load request and checks alignment and opcode legality. It then drives a variable-latency memory handshake, selects the addressed byte, halfword or full word and sign- or zero-extends it. The result is registered toward WB, and the pipeline is stalled until the access completes or times out.

## Interface
Parameters:
- DATA_W, 32, memory/register data width; 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT, 15, maximum WAIT cycles without mem_ready before abort; 1..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- req_valid  in  1  load request present; held stable by pipeline while stall=1.
- req_addr  in  ADDR_W  byte address.
- req_op  in  3  000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw (full DATA_W); others illegal.
- req_rd  in  5  destination register tag.
- stall  out  1  freeze upstream pipeline.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  req_addr with low log2(DATA_W/8) bits cleared.
- mem_ready  in  1  memory read data valid this cycle.
- mem_rdata  in  DATA_W  memory read data, lane 0 = lowest address (little-endian).
- wb_valid  out  1  one-cycle pulse, result valid.
- wb_data  out  DATA_W  extended load result.
- wb_rd  out  5  tag of completed load.
- exc_adel  out  1  one-cycle pulse: misaligned address or illegal op.
- exc_tmo  out  1  one-cycle pulse: memory timeout.
- exc_addr  out  ADDR_W  faulting address, valid with either exception pulse.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, req_valid=1, request illegal:
  - Illegal means op ∉ {000..100], half op with addr[0]=1, or full op with low log2(DATA_W/8) bits ≠0.
  - Next cycle: exc_adel=1, exc_addr=req_addr; state stays IDLE; no memory access.
- IDLE, req_valid=1, request legal: capture addr, op and rd; clear timeout counter; go to WAIT.
- WAIT: mem_req=1; mem_addr stable from captured address; counter increments each cycle.
  - mem_ready=1: latch extracted result into wb_data and wb_rd; go to RESP.
  - Otherwise, counter reaches TIMEOUT: exc_tmo and exc_addr pulse next cycle; go to RESP with wb_valid=0.
- RESP: wb_valid=1 only on normal completion; request inputs are ignored; go to IDLE.
- Lane select:
  - Byte: lane = addr[log2(DATA_W/8)-1:0].
  - Half: lane = addr[log2(DATA_W/8)-1:1].
- Extension: lb/lh replicate the selected MSB; lbu/lhu fill with zeros; lw passes the full word.
- mem_ready outside WAIT is ignored.
- Request inputs are ignored outside IDLE.

## Timing
- stall = (state==WAIT) | (state==IDLE & req_valid & legal).
  - Combinational from state and inputs; deasserted in RESP, so the pipeline advances on the RESP edge.
- Minimum latency: accept edge T, WAIT at T+1 with mem_ready=1, RESP at T+2 with wb_valid=1.
- Illegal request: exception pulse one cycle after presentation; stall is never asserted.
- Reset values: state=IDLE, stall=0 (given req_valid=0), mem_req=0, mem_addr=0, wb_valid=0, wb_data=0, wb_rd=0, exc_adel=0, exc_tmo=0, exc_addr=0, counter=0.
- Reset during WAIT or RESP: next cycle IDLE with all outputs at reset values; the pending access is dropped and any late mem_ready is ignored.
- mem_ready in the same cycle the counter reaches TIMEOUT: data wins, normal completion.
- wb_data and wb_rd hold their last value until the next completion.

## Test plan
- lb, DATA_W=32, addr=0x1003, mem_rdata=0x80FF_1234, ready after 2 WAIT cycles -> mem_addr=0x1000, wb_data=0xFFFF_FF80, wb_valid one cycle, stall high exactly 3 cycles.
- lhu, addr=0x2002, rdata=0x9ABC_5678, immediate ready -> wb_data=0x0000_9ABC; lh on same data -> 0xFFFF_9ABC.
- lw at 0x3001 -> exc_adel pulse, exc_addr=0x3001, mem_req never asserted, stall stays 0; repeat with op=111 -> same exc_adel behaviour.
- mem_ready held low, TIMEOUT=15 -> exc_tmo after 15 WAIT cycles, wb_valid stays 0, unit back in IDLE and accepts the next load.
- reset asserted in 2nd WAIT cycle, then mem_ready=1 -> all outputs 0, no wb_valid.
- DATA_W=64: lb at addr=0x...7, rdata=0x7F00_0000_0000_0000 -> wb_data=0x7F; lw at 0x...4 -> exc_adel.
